// File: rtl/i2s_tx_encoder.sv
// I2S / left-justified / right-justified serial transmitter with BCLK/LRCLK from MCLK.
// Optional: define I2S_TX_UNDERRUN_CNT_EN to add the o_underrun_cnt counter port.
module i2s_tx_encoder #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32,
    parameter int MCLK_DIV = 4,
    parameter int FORMAT   = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data_l,
    input  logic [DATA_W-1:0] i_data_r,
    input  logic              i_clr_underrun,
    output logic              o_bclk,
    output logic              o_lrclk,
    output logic              o_sdata,
    output logic              o_frame,
    output logic              o_underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       o_underrun_cnt
`endif
);

    localparam int FRAME = 2 * SLOT_W;
    localparam int BW    = (FRAME > 2) ? $clog2(FRAME) : 1;
    localparam int DW    = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
    localparam int OFS   = (FORMAT == 0) ? 1 :
                           (FORMAT == 1) ? 0 : SLOT_W - DATA_W;

    localparam logic [DW-1:0] DIV_LAST = DW'(MCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_MID  = DW'(MCLK_DIV / 2 - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(FRAME - 1);
    localparam logic [BW-1:0] B_LOAD   = BW'(OFS);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_W);
    localparam logic [BW:0]   FRAME_C  = (BW+1)'(FRAME);
    localparam logic [BW:0]   SHIFT_C  = (BW+1)'(FRAME - OFS);
    localparam logic [BW:0]   SLOT_C   = (BW+1)'(SLOT_W);

    if (DATA_W < 1 || DATA_W > SLOT_W) begin : g_bad_width
        $error("i2s_tx_encoder: DATA_W must be 1..SLOT_W");
    end
    if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_bad_div
        $error("i2s_tx_encoder: MCLK_DIV must be even and >= 2");
    end
    if (FORMAT < 0 || FORMAT > 2) begin : g_bad_fmt
        $error("i2s_tx_encoder: FORMAT must be 0, 1 or 2");
    end

    logic [DW-1:0]     div;
    logic [BW-1:0]     b;
    logic              hold_full;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] sh_l;
    logic [DATA_W-1:0] sh_r;

    logic              tick;
    logic [BW-1:0]     b_nxt;
    logic              load;
    logic              accept;
    logic [DATA_W-1:0] sh_l_n;
    logic [DATA_W-1:0] sh_r_n;
    logic              hold_full_n;
    logic              under_ev;
    logic [BW:0]       pos_sum;
    logic [BW:0]       pos;
    logic              ch;
    logic [BW:0]       k;
    logic [DATA_W-1:0] word;
    logic              bit_n;

    assign tick   = (div == DIV_LAST);
    assign b_nxt  = (b == B_LAST) ? '0 : b + 1'b1;
    assign load   = i_enable & tick & (b_nxt == B_LOAD);
    assign accept = i_valid & o_ready;

    // Frame load: take the held pair, a same-cycle pair, or zeros on underrun
    always_comb begin
        sh_l_n      = sh_l;
        sh_r_n      = sh_r;
        hold_full_n = hold_full;
        under_ev    = 1'b0;
        if (load) begin
            if (hold_full) begin
                sh_l_n      = hold_l;
                sh_r_n      = hold_r;
                hold_full_n = 1'b0;
            end else if (accept) begin
                sh_l_n = i_data_l;
                sh_r_n = i_data_r;
            end else begin
                sh_l_n   = '0;
                sh_r_n   = '0;
                under_ev = 1'b1;
            end
        end else if (accept) begin
            hold_full_n = 1'b1;
        end
    end

    // Map the upcoming bit slot to a channel and sample bit, MSB first
    always_comb begin
        pos_sum = {1'b0, b_nxt} + SHIFT_C;
        pos     = (pos_sum >= FRAME_C) ? pos_sum - FRAME_C : pos_sum;
        ch      = (pos >= SLOT_C);
        k       = ch ? pos - SLOT_C : pos;
        word    = ch ? sh_r_n : sh_l_n;
        bit_n   = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (k == (BW+1)'(i)) bit_n = word[DATA_W-1-i];
        end
    end

    // Divider, bit counter, buffer, shadow and all registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div        <= '0;
            b          <= '0;
            hold_full  <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            sh_l       <= '0;
            sh_r       <= '0;
            o_ready    <= 1'b0;
            o_bclk     <= 1'b0;
            o_lrclk    <= 1'b0;
            o_sdata    <= 1'b0;
            o_frame    <= 1'b0;
            o_underrun <= 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
            o_underrun_cnt <= '0;
`endif
        end else begin
            hold_full <= hold_full_n;
            o_ready   <= ~hold_full_n;
            o_frame   <= load;
            if (accept && !load) begin
                hold_l <= i_data_l;
                hold_r <= i_data_r;
            end
            if (under_ev) begin
                o_underrun <= 1'b1;
            end else if (i_clr_underrun) begin
                o_underrun <= 1'b0;
            end
`ifdef I2S_TX_UNDERRUN_CNT_EN
            if (under_ev) begin
                if (i_clr_underrun) begin
                    o_underrun_cnt <= 16'd1;
                end else if (o_underrun_cnt != 16'hFFFF) begin
                    o_underrun_cnt <= o_underrun_cnt + 16'd1;
                end
            end else if (i_clr_underrun) begin
                o_underrun_cnt <= '0;
            end
`endif
            if (!i_enable) begin
                div     <= '0;
                b       <= '0;
                sh_l    <= '0;
                sh_r    <= '0;
                o_bclk  <= 1'b0;
                o_lrclk <= 1'b0;
                o_sdata <= 1'b0;
            end else begin
                div  <= tick ? '0 : div + 1'b1;
                sh_l <= sh_l_n;
                sh_r <= sh_r_n;
                if (tick) begin
                    b       <= b_nxt;
                    o_bclk  <= 1'b0;
                    o_lrclk <= (b_nxt >= SLOT_B);
                    o_sdata <= bit_n;
                end else if (div == DIV_MID) begin
                    o_bclk <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_encoder.sv
// Directed bench for i2s_tx_encoder: default I2S, right-justified
// and full-width I2S instances share clock, reset and enable.
module tb_i2s_tx_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        clr;
    logic        v0, v2, v3;
    logic [15:0] l0, r0, l2, r2;
    logic [31:0] l3, r3;

    logic [2:0] ready_v, bclk_v, lr_v, sd_v, frame_v, und_v;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] cnt0, cnt2, cnt3;
`endif

    int tests = 0;
    int fails = 0;

    i2s_tx_encoder u0 (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .i_valid(v0), .o_ready(ready_v[0]),
        .i_data_l(l0), .i_data_r(r0),
        .i_clr_underrun(clr),
        .o_bclk(bclk_v[0]), .o_lrclk(lr_v[0]),
        .o_sdata(sd_v[0]), .o_frame(frame_v[0]),
        .o_underrun(und_v[0])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .o_underrun_cnt(cnt0)
`endif
    );

    i2s_tx_encoder #(.DATA_W(16), .SLOT_W(32),
                     .MCLK_DIV(4), .FORMAT(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .i_valid(v2), .o_ready(ready_v[1]),
        .i_data_l(l2), .i_data_r(r2),
        .i_clr_underrun(clr),
        .o_bclk(bclk_v[1]), .o_lrclk(lr_v[1]),
        .o_sdata(sd_v[1]), .o_frame(frame_v[1]),
        .o_underrun(und_v[1])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .o_underrun_cnt(cnt2)
`endif
    );

    i2s_tx_encoder #(.DATA_W(32), .SLOT_W(32),
                     .MCLK_DIV(4), .FORMAT(0)) u3 (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .i_valid(v3), .o_ready(ready_v[2]),
        .i_data_l(l3), .i_data_r(r3),
        .i_clr_underrun(clr),
        .o_bclk(bclk_v[2]), .o_lrclk(lr_v[2]),
        .o_sdata(sd_v[2]), .o_frame(frame_v[2]),
        .o_underrun(und_v[2])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .o_underrun_cnt(cnt3)
`endif
    );

    // Optionally sync to an LRCLK fall, then sample n bits on BCLK rises.
    task automatic capture(input int idx, input bit sync, input int n,
                           output logic [63:0] sd,
                           output logic [63:0] lr,
                           output bit ok);
        logic p;
        int   guard;
        bit   done;
        sd = '0;
        lr = '0;
        ok = 1'b1;
        if (sync) begin
            p = lr_v[idx];
            guard = 0;
            done = 1'b0;
            while (!done && ok) begin
                @(negedge clk);
                if (p && !lr_v[idx]) done = 1'b1;
                p = lr_v[idx];
                guard++;
                if (!done && guard > 600) ok = 1'b0;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (ok) begin
                p = bclk_v[idx];
                guard = 0;
                done = 1'b0;
                while (!done && ok) begin
                    @(negedge clk);
                    if (!p && bclk_v[idx]) done = 1'b1;
                    p = bclk_v[idx];
                    guard++;
                    if (!done && guard > 50) ok = 1'b0;
                end
                sd[n-1-i] = sd_v[idx];
                lr[n-1-i] = lr_v[idx];
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        v0 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        l0 = '0; r0 = '0; l2 = '0; r2 = '0; l3 = '0; r3 = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (ready_v !== 3'b000) begin
            fails++;
            $display("FAIL rst_ready got=%b exp=000", ready_v);
        end
        tests++;
        if ({bclk_v, lr_v, sd_v} !== 9'b0) begin
            fails++;
            $display("FAIL rst_serial got=%b exp=0",
                     {bclk_v, lr_v, sd_v});
        end
        tests++;
        if ({frame_v, und_v} !== 6'b0) begin
            fails++;
            $display("FAIL rst_flags got=%b exp=0", {frame_v, und_v});
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (ready_v !== 3'b111) begin
            fails++;
            $display("FAIL post_rst_ready got=%b exp=111", ready_v);
        end
    endtask

    task automatic test_stream;
        logic [63:0] sd, lr;
        bit ok;
        int c;
        logic p;
        l0 = 16'hA55A; r0 = 16'h0FF0; v0 = 1'b1;
        l2 = 16'hC3A5; r2 = 16'h1234; v2 = 1'b1;
        l3 = 32'h0;    r3 = 32'h1;    v3 = 1'b1;
        en = 1'b1;
        capture(0, 1'b0, 1, sd, lr, ok);
        c = 0;
        p = 1'b1;
        while (ok && !(!p && bclk_v[0]) && c < 20) begin
            p = bclk_v[0];
            @(negedge clk);
            c++;
        end
        tests++;
        if (!ok || c != 4) begin
            fails++;
            $display("FAIL bclk_period got=%0d exp=4", c);
        end
        capture(0, 1'b1, 0, sd, lr, ok);
        c = 0;
        p = 1'b0;
        while (ok && !(p && !lr_v[0]) && c < 600) begin
            p = lr_v[0];
            @(negedge clk);
            c++;
        end
        tests++;
        if (!ok || c != 256) begin
            fails++;
            $display("FAIL lrclk_period got=%0d exp=256", c);
        end
        capture(0, 1'b1, 64, sd, lr, ok);
        tests++;
        if (!ok || sd !== {1'b0, 16'hA55A, 16'h0, 16'h0FF0, 15'h0}) begin
            fails++;
            $display("FAIL i2s_sdata got=%h exp=%h", sd,
                     {1'b0, 16'hA55A, 16'h0, 16'h0FF0, 15'h0});
        end
        tests++;
        if (!ok || lr !== {32'h0, 32'hFFFF_FFFF}) begin
            fails++;
            $display("FAIL i2s_lrclk got=%h exp=%h", lr,
                     {32'h0, 32'hFFFF_FFFF});
        end
    endtask

    task automatic test_right_justified;
        logic [63:0] sd, lr;
        bit ok;
        capture(1, 1'b1, 64, sd, lr, ok);
        tests++;
        if (!ok || sd !== {16'h0, 16'hC3A5, 16'h0, 16'h1234}) begin
            fails++;
            $display("FAIL rj_sdata got=%h exp=%h", sd,
                     {16'h0, 16'hC3A5, 16'h0, 16'h1234});
        end
    endtask

    task automatic test_wrap_bit;
        logic [63:0] sd, lr;
        bit ok;
        capture(2, 1'b1, 0, sd, lr, ok);
        l3 = 32'hDEAD_BEEF;
        r3 = 32'h0;
        capture(2, 1'b1, 64, sd, lr, ok);
        tests++;
        if (!ok || sd !== {1'b1, 32'hDEAD_BEEF, 31'h0}) begin
            fails++;
            $display("FAIL wrap_sdata got=%h exp=%h", sd,
                     {1'b1, 32'hDEAD_BEEF, 31'h0});
        end
        v3 = 1'b0;
    endtask

    task automatic test_underrun;
        logic [63:0] sd, lr;
        bit ok;
        capture(0, 1'b1, 0, sd, lr, ok);
        v0 = 1'b0;
        tests++;
        if (!ok || und_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL und_before got=%b exp=0", und_v[0]);
        end
        capture(0, 1'b1, 64, sd, lr, ok);
        tests++;
        if (!ok || sd !== 64'h0) begin
            fails++;
            $display("FAIL und_sdata got=%h exp=0", sd);
        end
        tests++;
        if (und_v[0] !== 1'b1) begin
            fails++;
            $display("FAIL und_set got=%b exp=1", und_v[0]);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tests++;
        if (und_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL und_clr got=%b exp=0", und_v[0]);
        end
`ifdef I2S_TX_UNDERRUN_CNT_EN
        repeat (3) capture(0, 1'b1, 0, sd, lr, ok);
        repeat (8) @(negedge clk);
        tests++;
        if (cnt0 !== 16'd3) begin
            fails++;
            $display("FAIL und_cnt got=%0d exp=3", cnt0);
        end
`endif
    endtask

    task automatic test_load_cycle_accept;
        logic [63:0] sd, lr;
        bit ok;
        capture(0, 1'b1, 0, sd, lr, ok);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        l0 = 16'h5AC3;
        r0 = 16'h0;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        tests++;
        if (!ok || frame_v[0] !== 1'b1) begin
            fails++;
            $display("FAIL exact_frame got=%b exp=1", frame_v[0]);
        end
        tests++;
        if ({und_v[0], ready_v[0]} !== 2'b01) begin
            fails++;
            $display("FAIL exact_flags got=%b exp=01",
                     {und_v[0], ready_v[0]});
        end
        capture(0, 1'b0, 16, sd, lr, ok);
        tests++;
        if (!ok || sd[15:0] !== 16'h5AC3) begin
            fails++;
            $display("FAIL exact_data got=%h exp=5ac3", sd[15:0]);
        end
    endtask

    task automatic test_enable_reset;
        logic [63:0] sd, lr;
        bit ok;
        l0 = 16'hA55A;
        r0 = 16'h0FF0;
        v0 = 1'b1;
        capture(0, 1'b1, 0, sd, lr, ok);
        capture(0, 1'b1, 0, sd, lr, ok);
        repeat (26) @(negedge clk);
        tests++;
        if (!ok || {bclk_v[0], lr_v[0], sd_v[0]} !== 3'b101) begin
            fails++;
            $display("FAIL mid_left got=%b exp=101",
                     {bclk_v[0], lr_v[0], sd_v[0]});
        end
        en = 1'b0;
        v0 = 1'b0;
        @(negedge clk);
        tests++;
        if ({bclk_v, lr_v, sd_v} !== 9'b0) begin
            fails++;
            $display("FAIL dis_serial got=%b exp=0",
                     {bclk_v, lr_v, sd_v});
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({ready_v, und_v, frame_v} !== 9'b0) begin
            fails++;
            $display("FAIL in_rst got=%b exp=0",
                     {ready_v, und_v, frame_v});
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (ready_v !== 3'b111) begin
            fails++;
            $display("FAIL after_rst got=%b exp=111", ready_v);
        end
        l0 = 16'h8001;
        r0 = 16'h7FFE;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if ({ready_v[0], und_v[0]} !== 2'b00) begin
            fails++;
            $display("FAIL idle_hold got=%b exp=00",
                     {ready_v[0], und_v[0]});
        end
        en = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if ({frame_v[0], ready_v[0]} !== 2'b11) begin
            fails++;
            $display("FAIL first_load got=%b exp=11",
                     {frame_v[0], ready_v[0]});
        end
        capture(0, 1'b0, 16, sd, lr, ok);
        tests++;
        if (!ok || sd[15:0] !== 16'h8001) begin
            fails++;
            $display("FAIL restart_data got=%h exp=8001", sd[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_right_justified();
        test_wrap_bit();
        test_underrun();
        test_load_cycle_accept();
        test_enable_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
